// File: rtl/uart_alu_cmd_seq_pkg.sv
// Shared definitions for the UART/ALU command sequencer: FSM states,
// response status codes, response length and default sync bytes.
package uart_alu_cmd_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_GET_OP  = 4'd1,
    ST_GET_A   = 4'd2,
    ST_GET_B   = 4'd3,
    ST_GET_CHK = 4'd4,
    ST_CHECK   = 4'd5,
    ST_EXEC    = 4'd6,
    ST_SEND    = 4'd7
  } state_t;

  localparam logic [7:0] STAT_OK      = 8'h00;
  localparam logic [7:0] STAT_BAD_CHK = 8'h01;
  localparam logic [7:0] STAT_TIMEOUT = 8'h02;

  localparam int RSP_LEN = 4;

  localparam logic [7:0] DEF_SYNC_RX = 8'hA5;
  localparam logic [7:0] DEF_SYNC_TX = 8'h5A;

endpackage

// File: rtl/uart_alu_cmd_seq_rsp_tx.sv
// Response serializer: latches STAT/RES on a start pulse and pushes
// SYNC_TX, STAT, RES, STAT^RES into the TX FIFO, one byte per free cycle.
module uart_alu_cmd_seq_rsp_tx
  import uart_alu_cmd_seq_pkg::*;
#(
  parameter int                   DATA_BITS = 8,
  parameter logic [DATA_BITS-1:0] SYNC_TX   = DATA_BITS'(DEF_SYNC_TX)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [DATA_BITS-1:0] i_stat,
  input  logic [DATA_BITS-1:0] i_res,
  input  logic                 i_tx_full,
  output logic [DATA_BITS-1:0] o_w_data,
  output logic                 o_wr_uart,
  output logic                 o_done
);

  logic                 r_active;
  logic [1:0]           r_idx;
  logic [DATA_BITS-1:0] r_stat;
  logic [DATA_BITS-1:0] r_res;
  logic                 w_push;
  logic                 w_last;

  // Handshake: a byte is written on the edge where o_wr_uart is high;
  // o_wr_uart is only raised while the TX FIFO reports room.
  assign w_push    = r_active && !i_tx_full;
  assign w_last    = (r_idx == 2'(RSP_LEN - 1));
  assign o_wr_uart = w_push;
  assign o_done    = w_push && w_last;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_active <= 1'b0;
      r_idx    <= 2'd0;
      r_stat   <= '0;
      r_res    <= '0;
    end else if (i_start && !r_active) begin
      r_active <= 1'b1;
      r_idx    <= 2'd0;
      r_stat   <= i_stat;
      r_res    <= i_res;
    end else if (w_push) begin
      if (w_last) begin
        r_active <= 1'b0;
        r_idx    <= 2'd0;
      end else begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  always_comb begin
    o_w_data = '0;
    if (r_active) begin
      case (r_idx)
        2'd0:    o_w_data = SYNC_TX;
        2'd1:    o_w_data = r_stat;
        2'd2:    o_w_data = r_res;
        default: o_w_data = r_stat ^ r_res;
      endcase
    end
  end

endmodule

// File: rtl/uart_alu_cmd_seq.sv
// Framed command sequencer between the UART FIFOs and a combinational ALU:
// parses A5/OPC/A/B/CHK frames, commits operands and answers with a 4-byte status frame.
module uart_alu_cmd_seq
  import uart_alu_cmd_seq_pkg::*;
#(
  parameter int                   DATA_BITS   = 8,
  parameter int                   OPCODE_BITS = 6,
  parameter logic [DATA_BITS-1:0] SYNC_RX     = DATA_BITS'(DEF_SYNC_RX),
  parameter logic [DATA_BITS-1:0] SYNC_TX     = DATA_BITS'(DEF_SYNC_TX),
  parameter int                   TIMEOUT_CYC = 1000000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_rx_empty,
  input  logic [DATA_BITS-1:0]   i_r_data,
  output logic                   o_rd_uart,
  input  logic                   i_tx_full,
  output logic [DATA_BITS-1:0]   o_w_data,
  output logic                   o_wr_uart,
  input  logic [DATA_BITS-1:0]   i_result_data,
  output logic [DATA_BITS-1:0]   o_op_a,
  output logic [DATA_BITS-1:0]   o_op_b,
  output logic [OPCODE_BITS-1:0] o_op_code,
  output logic                   o_busy,
  output logic                   o_frame_ok,
  output logic                   o_frame_err,
  output logic [3:0]             o_dbg_state
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  state_t                 r_state;
  logic [DATA_BITS-1:0]   r_sh_op;
  logic [DATA_BITS-1:0]   r_sh_a;
  logic [DATA_BITS-1:0]   r_sh_b;
  logic [DATA_BITS-1:0]   r_sh_chk;
  logic [TMR_W-1:0]       r_timer;
  logic [DATA_BITS-1:0]   r_op_a;
  logic [DATA_BITS-1:0]   r_op_b;
  logic [OPCODE_BITS-1:0] r_op_code;
  logic                   r_frame_ok;
  logic                   r_frame_err;

  logic                   w_in_get;
  logic                   w_pop;
  logic                   w_to_hit;
  logic                   w_chk_ok;
  logic                   w_tx_start;
  logic [DATA_BITS-1:0]   w_tx_stat;
  logic [DATA_BITS-1:0]   w_tx_res;
  logic                   w_tx_done;

  assign w_in_get = (r_state inside {ST_GET_OP, ST_GET_A, ST_GET_B, ST_GET_CHK});
  assign w_pop    = (w_in_get || (r_state == ST_IDLE)) && !i_rx_empty;
  assign w_to_hit = w_in_get && !w_pop && (r_timer == TMR_W'(TIMEOUT_CYC - 1));
  assign w_chk_ok = ((r_sh_op ^ r_sh_a ^ r_sh_b) == r_sh_chk);

  // Handshake: the RX head byte is consumed on the edge where o_rd_uart is high.
  assign o_rd_uart   = w_pop && i_reset;
  assign o_op_a      = r_op_a;
  assign o_op_b      = r_op_b;
  assign o_op_code   = r_op_code;
  assign o_frame_ok  = r_frame_ok;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

  // The serializer is kicked in the cycle the response content is known,
  // so its first push lands on the following cycle.
  always_comb begin
    w_tx_start = 1'b0;
    w_tx_stat  = '0;
    w_tx_res   = '0;
    if (r_state == ST_EXEC) begin
      w_tx_start = 1'b1;
      w_tx_stat  = DATA_BITS'(STAT_OK);
      w_tx_res   = i_result_data;
    end else if ((r_state == ST_CHECK) && !w_chk_ok) begin
      w_tx_start = 1'b1;
      w_tx_stat  = DATA_BITS'(STAT_BAD_CHK);
    end else if (w_to_hit) begin
      w_tx_start = 1'b1;
      w_tx_stat  = DATA_BITS'(STAT_TIMEOUT);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_sh_op     <= '0;
      r_sh_a      <= '0;
      r_sh_b      <= '0;
      r_sh_chk    <= '0;
      r_timer     <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_code   <= '0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;

      if (w_in_get && !w_pop && !w_to_hit) begin
        r_timer <= r_timer + TMR_W'(1);
      end else begin
        r_timer <= '0;
      end

      if (w_to_hit) begin
        r_state     <= ST_SEND;
        r_frame_err <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_pop && (i_r_data == SYNC_RX)) r_state <= ST_GET_OP;
          end
          ST_GET_OP: begin
            if (w_pop) begin
              r_sh_op <= i_r_data;
              r_state <= ST_GET_A;
            end
          end
          ST_GET_A: begin
            if (w_pop) begin
              r_sh_a  <= i_r_data;
              r_state <= ST_GET_B;
            end
          end
          ST_GET_B: begin
            if (w_pop) begin
              r_sh_b  <= i_r_data;
              r_state <= ST_GET_CHK;
            end
          end
          ST_GET_CHK: begin
            if (w_pop) begin
              r_sh_chk <= i_r_data;
              r_state  <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (w_chk_ok) begin
              r_op_a     <= r_sh_a;
              r_op_b     <= r_sh_b;
              r_op_code  <= r_sh_op[OPCODE_BITS-1:0];
              r_frame_ok <= 1'b1;
              r_state    <= ST_EXEC;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_SEND;
            end
          end
          ST_EXEC: r_state <= ST_SEND;
          ST_SEND: begin
            if (w_tx_done) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  uart_alu_cmd_seq_rsp_tx #(
    .DATA_BITS (DATA_BITS),
    .SYNC_TX   (SYNC_TX)
  ) u_rsp_tx (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (w_tx_start),
    .i_stat    (w_tx_stat),
    .i_res     (w_tx_res),
    .i_tx_full (i_tx_full),
    .o_w_data  (o_w_data),
    .o_wr_uart (o_wr_uart),
    .o_done    (w_tx_done)
  );

endmodule
